// File: rtl/ex_pkg.sv
// ============================================================================
// ex_pkg : shared codes for the EX stage (ALU ops, mul/div ops, md FSM state)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Nine md operations share a 3-bit field: MTHI/MTLO use one code and
  // i_aluctrl[0] picks the target (0 = HI, 1 = LO).
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;
  localparam logic [2:0] MD_MTX   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_muldiv_muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative shift-add multiply / restoring divide with HI/LO
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_r, div_diff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    dvd_d    = dvd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    signed_op = (i_op == MD_MULT) || (i_op == MD_DIV);
    div_op    = (i_op == MD_DIV) || (i_op == MD_DIVU);
    a_neg     = signed_op & i_a[WIDTH-1];
    b_neg     = signed_op & i_b[WIDTH-1];
    a_mag     = a_neg ? -i_a : i_a;
    b_mag     = b_neg ? -i_b : i_b;

    // prod_q holds {accumulator, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide.
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    div_r    = prod_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_r - {1'b0, mcand_q};

    case (state_q)
      MD_IDLE: begin
        if (i_start) begin
          state_d  = MD_BUSY;
          cnt_d    = CW'(WIDTH);
          is_div_d = div_op;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = (i_b == '0);
          dvd_d    = i_a;
          mcand_d  = div_op ? b_mag : a_mag;
          prod_d   = {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
        end else begin
          if (i_wr_hi) hi_d = i_wdata;
          if (i_wr_lo) lo_d = i_wdata;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div_q) begin
          if (div_diff[WIDTH]) prod_d = {div_r[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
          else                 prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = dvd_q;
          end else begin
            lo_d = neg_lo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
            hi_d = neg_hi_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -prod_q : prod_q;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      dvd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      dvd_q    <= dvd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign o_busy = (state_q != MD_IDLE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
// ============================================================================
// ex_stage_muldiv : MIPS execute stage - ALU, EX/MEM register, mul/div stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic [15:0]      i_imm,
  input  logic             i_extop,
  input  logic             i_alusrc,
  input  logic [3:0]       i_aluctrl,
  input  logic [2:0]       i_mdop,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_alures,
  output logic [WIDTH-1:0] o_op2,
  output logic             o_zero
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] imm_ext, alu_b, alu_res, lui_res, ex_res, hi, lo;
  logic [SHW-1:0]   shamt;
  logic             md_busy, accept, md_start, wr_hi, wr_lo;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alures_q, alures_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             zero_q, zero_d;

  assign imm_ext = i_extop ? WIDTH'($signed(i_imm)) : WIDTH'(i_imm);
  assign alu_b   = i_alusrc ? imm_ext : i_op2;
  assign shamt   = i_op1[SHW-1:0];

  generate
    if (WIDTH >= 32) begin : g_lui_shift
      assign lui_res = alu_b << 16;
    end else begin : g_lui_pass
      assign lui_res = alu_b;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (i_aluctrl)
      ALU_ADD:  alu_res = i_op1 + alu_b;
      ALU_SUB:  alu_res = i_op1 - alu_b;
      ALU_AND:  alu_res = i_op1 & alu_b;
      ALU_OR:   alu_res = i_op1 | alu_b;
      ALU_XOR:  alu_res = i_op1 ^ alu_b;
      ALU_NOR:  alu_res = ~(i_op1 | alu_b);
      ALU_SLT:  alu_res = WIDTH'($signed(i_op1) < $signed(alu_b));
      ALU_SLTU: alu_res = WIDTH'(i_op1 < alu_b);
      ALU_SLL:  alu_res = alu_b << shamt;
      ALU_SRL:  alu_res = alu_b >> shamt;
      ALU_SRA:  alu_res = WIDTH'($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_res = lui_res;
      default:  alu_res = '0;
    endcase
  end

  // Any md op while the unit is busy must wait; plain ALU ops slip past.
  assign o_stall  = i_valid & md_busy & (i_mdop != MD_NONE);
  assign accept   = i_valid & ~o_stall & ~i_flush;
  assign md_start = accept & md_is_arith(i_mdop);
  assign wr_hi    = accept & (i_mdop == MD_MTX) & ~i_aluctrl[0];
  assign wr_lo    = accept & (i_mdop == MD_MTX) &  i_aluctrl[0];

  assign ex_res = (i_mdop == MD_MFHI) ? hi :
                  (i_mdop == MD_MFLO) ? lo : alu_res;

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (md_start),
    .i_op    (i_mdop),
    .i_a     (i_op1),
    .i_b     (i_op2),
    .i_wr_hi (wr_hi),
    .i_wr_lo (wr_lo),
    .i_wdata (i_op1),
    .o_busy  (md_busy),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  always_comb begin
    valid_d  = accept;
    alures_d = accept ? ex_res : '0;
    op2_d    = accept ? i_op2 : '0;
    zero_d   = (alures_d == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      alures_q <= '0;
      op2_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      alures_q <= alures_d;
      op2_q    <= op2_d;
      zero_q   <= zero_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_alures = alures_q;
  assign o_op2    = op2_q;
  assign o_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
// ============================================================================
// tb_ex_stage_muldiv : directed vectors for the EX stage and mul/div unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage_muldiv;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        valid, flush, extop, alusrc, stall, ovalid, zero;
  logic [31:0] op1, op2, alures, oop2;
  logic [15:0] imm;
  logic [3:0]  aluctrl;
  logic [2:0]  mdop;

  logic        valid_h, flush_h, extop_h, alusrc_h, stall_h, ovalid_h, zero_h;
  logic [15:0] op1_h, op2_h, alures_h, oop2_h, imm_h;
  logic [3:0]  aluctrl_h;
  logic [2:0]  mdop_h;

  int total = 0;
  int bad   = 0;

  ex_stage_muldiv #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flush(flush),
    .i_op1(op1), .i_op2(op2), .i_imm(imm), .i_extop(extop), .i_alusrc(alusrc),
    .i_aluctrl(aluctrl), .i_mdop(mdop), .o_stall(stall), .o_valid(ovalid),
    .o_alures(alures), .o_op2(oop2), .o_zero(zero)
  );

  ex_stage_muldiv #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_h), .i_flush(flush_h),
    .i_op1(op1_h), .i_op2(op2_h), .i_imm(imm_h), .i_extop(extop_h), .i_alusrc(alusrc_h),
    .i_aluctrl(aluctrl_h), .i_mdop(mdop_h), .o_stall(stall_h), .o_valid(ovalid_h),
    .o_alures(alures_h), .o_op2(oop2_h), .o_zero(zero_h)
  );

  typedef struct {
    logic [3:0]  ac;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
    logic        ex;
    logic        src;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ac, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                       input logic ex, input logic src, input logic fl);
    valid = v; aluctrl = ac; mdop = md; op1 = a; op2 = b;
    imm = im; extop = ex; alusrc = src; flush = fl;
  endtask

  task automatic md(input logic [2:0] op, input logic [3:0] ac, input logic [31:0] a,
                    input logic [31:0] b, input logic fl);
    drive(1'b1, ac, op, a, b, 16'd0, 1'b0, 1'b0, fl);
  endtask

  // Waits while the 32-bit DUT stalls; n counts edges since the md op was accepted.
  task automatic wait_stall(input string name, input int expect_edges, input int start);
    int n = start;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(expect_edges));
  endtask

  task automatic md_run(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    md(op, ALU_ADD, a, b, 1'b0);
    tick();
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    #1;
    wait_stall({name, "_lat"}, 33, 0);
    tick();
    check({name, "_lo"}, 64'(alures), 64'(exp_lo));
    md(MD_MFHI, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check({name, "_hi"}, 64'(alures), 64'(exp_hi));
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD,  32'd5,          32'd0,          16'd7,      1'b1, 1'b1, 32'd12};
    vecs[1]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          16'd0,      1'b0, 1'b0, 32'd1};
    vecs[2]  = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          16'd0,      1'b0, 1'b0, 32'd0};
    vecs[3]  = '{ALU_SUB,  32'd3,          32'd5,          16'd0,      1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[4]  = '{ALU_AND,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  16'd0,      1'b0, 1'b0, 32'h00F0_00F0};
    vecs[5]  = '{ALU_OR,   32'h0000_1200,  32'h0000_0034,  16'd0,      1'b0, 1'b0, 32'h0000_1234};
    vecs[6]  = '{ALU_XOR,  32'hFFFF_0000,  32'hFF00_FF00,  16'd0,      1'b0, 1'b0, 32'h00FF_FF00};
    vecs[7]  = '{ALU_NOR,  32'd0,          32'd0,          16'd0,      1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[8]  = '{ALU_SLL,  32'd4,          32'd1,          16'd0,      1'b0, 1'b0, 32'd16};
    vecs[9]  = '{ALU_SRL,  32'd4,          32'h8000_0000,  16'd0,      1'b0, 1'b0, 32'h0800_0000};
    vecs[10] = '{ALU_SRA,  32'd4,          32'h8000_0000,  16'd0,      1'b0, 1'b0, 32'hF800_0000};
    vecs[11] = '{ALU_LUI,  32'd0,          32'd0,          16'h1234,   1'b0, 1'b1, 32'h1234_0000};
    vecs[12] = '{ALU_ADD,  32'd1,          32'd0,          16'hFFFF,   1'b1, 1'b1, 32'd0};
    vecs[13] = '{ALU_ADD,  32'd1,          32'd0,          16'hFFFF,   1'b0, 1'b1, 32'h0001_0000};
    vecs[14] = '{4'd15,    32'd5,          32'd6,          16'd0,      1'b0, 1'b0, 32'd0};
    vecs[15] = '{ALU_SLL,  32'h21,         32'd1,          16'd0,      1'b0, 1'b0, 32'd2};

    rst = 1'b1;
    drive(1'b0, ALU_ADD, MD_NONE, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    valid_h = 1'b0; flush_h = 1'b0; op1_h = '0; op2_h = '0; imm_h = '0;
    extop_h = 1'b0; alusrc_h = 1'b0; aluctrl_h = ALU_ADD; mdop_h = MD_NONE;
    tick();
    check("rst_valid",  64'(ovalid), 64'd0);
    check("rst_alures", 64'(alures), 64'd0);
    check("rst_op2",    64'(oop2),   64'd0);
    check("rst_zero",   64'(zero),   64'd0);
    check("rst_stall",  64'(stall),  64'd0);
    check("rst_valid16", 64'(ovalid_h), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].ac, MD_NONE, vecs[i].a, vecs[i].b, vecs[i].im,
            vecs[i].ex, vecs[i].src, 1'b0);
      tick();
      check($sformatf("alu%0d_res", i),   64'(alures), 64'(vecs[i].exp));
      check($sformatf("alu%0d_zero", i),  64'(zero),   64'(vecs[i].exp == 32'd0));
      check($sformatf("alu%0d_valid", i), 64'(ovalid), 64'd1);
      check($sformatf("alu%0d_op2", i),   64'(oop2),   64'(vecs[i].b));
    end

    // MULT -3 x 4 with MFLO two cycles after acceptance
    md(MD_MULT, ALU_ADD, 32'hFFFF_FFFD, 32'd4, 1'b0);
    tick();
    check("mult_acc_valid", 64'(ovalid), 64'd1);
    drive(1'b0, ALU_ADD, MD_NONE, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    #1;
    check("mult_stall", 64'(stall), 64'd1);
    tick();
    check("mult_bubble", 64'(ovalid), 64'd0);
    wait_stall("mult_lat", 33, 2);
    tick();
    check("mult_lo", 64'(alures), 64'hFFFF_FFF4);
    check("mult_lo_valid", 64'(ovalid), 64'd1);
    md(MD_MFHI, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check("mult_hi", 64'(alures), 64'hFFFF_FFFF);

    md_run("div",    MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    md_run("divu0",  MD_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9);
    md_run("divmin", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    md_run("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    md_run("divneg", MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // ALU op proceeds during BUSY; a second MULT waits
    md(MD_MULT, ALU_ADD, 32'd6, 32'd7, 1'b0);
    tick();
    drive(1'b1, ALU_ADD, MD_NONE, 32'd2, 32'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("busy_add_stall", 64'(stall), 64'd0);
    tick();
    check("busy_add_res",   64'(alures), 64'd5);
    check("busy_add_valid", 64'(ovalid), 64'd1);
    md(MD_MULT, ALU_ADD, 32'd5, 32'd5, 1'b0);
    #1;
    check("busy_mult_stall", 64'(stall), 64'd1);
    tick();
    check("busy_mult_bubble", 64'(ovalid), 64'd0);
    wait_stall("busy_mult_wait", 33, 2);
    tick();
    check("mult2_acc_valid", 64'(ovalid), 64'd1);
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    #1;
    wait_stall("mult2_lat", 33, 0);
    tick();
    check("mult2_lo", 64'(alures), 64'd25);

    // Flushed md ops must not start or write
    md(MD_MULT, ALU_ADD, 32'd2, 32'd3, 1'b1);
    tick();
    check("flush_mult_valid", 64'(ovalid), 64'd0);
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    #1;
    check("flush_mult_nostall", 64'(stall), 64'd0);
    tick();
    check("flush_mult_lo", 64'(alures), 64'd25);
    md(MD_MTX, 4'd1, 32'h0000_ABCD, 32'd0, 1'b1);
    tick();
    check("flush_mtlo_valid", 64'(ovalid), 64'd0);
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check("flush_mtlo_lo", 64'(alures), 64'd25);
    md(MD_MTX, 4'd1, 32'h0000_ABCD, 32'd0, 1'b0);
    tick();
    md(MD_MTX, 4'd0, 32'h0000_1111, 32'd0, 1'b0);
    tick();
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check("mtlo_lo", 64'(alures), 64'h0000_ABCD);
    md(MD_MFHI, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check("mthi_hi", 64'(alures), 64'h0000_1111);

    // Reset in the middle of a DIV
    md(MD_DIV, ALU_ADD, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b1, ALU_ADD, MD_NONE, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) tick();
    check("prerst_valid", 64'(ovalid), 64'd1);
    md(MD_MFLO, ALU_ADD, 32'd0, 32'd0, 1'b0);
    #1;
    check("prerst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_stall",  64'(stall),  64'd0);
    check("midrst_valid",  64'(ovalid), 64'd0);
    check("midrst_alures", 64'(alures), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    check("postrst_lo",       64'(alures), 64'd0);
    check("postrst_lo_valid", 64'(ovalid), 64'd1);
    md(MD_MFHI, ALU_ADD, 32'd0, 32'd0, 1'b0);
    tick();
    check("postrst_hi", 64'(alures), 64'd0);
    drive(1'b0, ALU_ADD, MD_NONE, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // WIDTH=16 instance: MULT -3 x 4
    valid_h = 1'b1; mdop_h = MD_MULT; op1_h = 16'hFFFD; op2_h = 16'd4;
    tick();
    mdop_h = MD_MFLO;
    #1;
    begin
      int n = 0;
      while (stall_h && n < 200) begin
        tick();
        n++;
      end
      check("w16_lat", 64'(n), 64'd17);
    end
    tick();
    check("w16_lo",    64'(alures_h), 64'h0000_FFF4);
    check("w16_valid", 64'(ovalid_h), 64'd1);
    valid_h = 1'b0;
    mdop_h  = MD_NONE;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
Parametrised pipelined execute stage for the MIPS core: ALU with immediate extension and operand select, registered EX/MEM output, and an iterative multiply/divide unit with HI/LO registers. Sits between the ID/EX and EX/MEM boundaries. Branch/jump resolution is done in decode and is not part of this block. Stalls upstream only on multiply/divide hazards.

Parameters:
WIDTH, 32, datapath width (power of two, >=8)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  instruction present at EX input
i_flush  in  1  kill instruction entering EX/MEM this cycle
i_op1  in  WIDTH  rs operand
i_op2  in  WIDTH  rt operand
i_imm  in  16  immediate field
i_extop  in  1  1=sign-extend imm, 0=zero-extend
i_alusrc  in  1  1=ALU B from extended imm, 0=i_op2
i_aluctrl  in  4  ALU operation (package codes)
i_mdop  in  3  mul/div operation (package codes)
o_stall  out  1  hold upstream; EX input not accepted
o_valid  out  1  EX/MEM valid
o_alures  out  WIDTH  registered result (ALU or MFHI/MFLO)
o_op2  out  WIDTH  registered i_op2 (store data)
o_zero  out  1  registered (result == 0)

Behaviour:
- Reset: o_valid=0, o_alures=0, o_op2=0, o_zero=0, HI=LO=0, md state IDLE, counter 0, o_stall=0. Reset mid-operation aborts the operation; no partial result written.
- ALU (combinational, registered into EX/MEM, latency 1): ADD, SUB (wrap, no trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (B shifted by i_op1[SHW-1:0]), LUI (B<<16 when WIDTH>=32, else B). Undefined code -> result 0.
- Extension: imm sign/zero-extended to WIDTH per i_extop.
- i_mdop: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- md FSM: IDLE -> BUSY on accepted MULT/MULTU/DIV/DIVU; latch magnitudes (signed ops) plus result sign flags; counter=WIDTH. BUSY: one bit per cycle (shift-add multiply, restoring divide); counter decrements; at 0 -> FIX. FIX: apply signs, write HI/LO, -> IDLE. HI/LO valid WIDTH+1 cycles after acceptance.
- Results: multiply HI:LO = 2*WIDTH product. Divide LO=quotient, HI=remainder (remainder sign = dividend sign). Divide by zero: LO=all ones, HI=dividend. MIN/-1 signed: LO=MIN, HI=0.
- Accepted mul/div instruction itself flows to EX/MEM with o_valid=1 (no register write downstream; decode owns write enables).
- o_stall = i_valid and (state != IDLE) and (i_mdop != NONE). Non-md instructions proceed while BUSY.
- While o_stall: EX/MEM loads bubble (o_valid=0); input not consumed.
- MFHI/MFLO in IDLE: o_alures = HI/LO. MTHI/MTLO in IDLE: write i_op1 into HI/LO at the same edge.
- i_flush: EX/MEM loads bubble; a flushed MULT/DIV/MTHI/MTLO does not start/write. A flush does not abort an already-running operation.
- o_zero = (registered result == 0), including bubbles.

Decomposition:
- Package ex_pkg: ALU control codes, mdop codes, md state enum.
- One sub-module: muldiv_unit (FSM, counter, HI/LO, sign fixup); top holds ALU, extender, operand mux, EX/MEM register, stall logic.

Test Plan:
- After reset, ADD op1=5, imm=7, alusrc=1, extop=1 -> next cycle o_valid=1, o_alures=12, o_zero=0; SLT -1 vs 1 -> 1, SLTU -1 vs 1 -> 0.
- MULT -3 x 4, then MFLO issued 2 cycles later -> o_stall high until FIX done (33 cycles total for WIDTH=32), then o_alures=0xFFFFFFF4; MFHI -> 0xFFFFFFFF.
- DIV 7 / -2 -> LO=0xFFFFFFFD, HI=1; DIVU 9 / 0 -> LO=0xFFFFFFFF, HI=9.
- ADD issued during BUSY -> no stall, result 1 cycle later; second MULT during BUSY -> stalled until IDLE.
- MULT with i_flush=1 -> no operation started, HI/LO unchanged, o_valid=0.
- Assert i_rst at cycle 10 of DIV -> HI=LO=0, o_stall=0, o_valid=0 immediately; WIDTH=16 instance repeats MULT -3 x 4 -> LO=0xFFF4 after 17 cycles.
